// File: rtl/glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_pulse_gen
//  Purpose  : On a rising edge of the delayed trigger, emits a burst of
//             `count` glitch pulses. Each pulse lasts `width` clk cycles and
//             consecutive pulses are separated by max(gap,1) idle cycles.
//             Width, gap and count are loaded through the set_config strobe.
//             Each burst runs on a snapshot of that configuration, taken at
//             the trigger edge.
//  Ports    : clk        - system clock
//             rst        - asynchronous reset, active low
//             trigger    - delayed trigger, synchronous to clk
//             width      - pulse width in clk cycles
//             gap        - inter-pulse gap in clk cycles (0 behaves as 1)
//             count      - number of pulses per burst
//             set_config - load strobe for width/gap/count
//             glitch_out - glitch drive (OUT_ACTIVE while a pulse is active)
//             busy       - high while a burst is in progress
//             done       - one-cycle pulse after the last pulse of a burst
//             clamped    - sticky flag: a burst had its width clamped
//  Options  : define GLITCH_CLAMP_EN to limit the snapshot width to MAX_WIDTH
//             and to enable the clamped flag. When the macro is undefined,
//             clamped is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module glitch_pulse_gen #(
   parameter int WIDTH_BITS = 16,
   parameter int COUNT_BITS = 8,
   parameter int MAX_WIDTH  = 1000,
   parameter int OUT_ACTIVE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trigger,
   input  logic [WIDTH_BITS-1:0] width,
   input  logic [WIDTH_BITS-1:0] gap,
   input  logic [COUNT_BITS-1:0] count,
   input  logic                  set_config,
   output logic                  glitch_out,
   output logic                  busy,
   output logic                  done,
   output logic                  clamped
);

   localparam logic                  c_on    = (OUT_ACTIVE != 0);
   localparam logic                  c_off   = ~c_on;
   localparam logic [WIDTH_BITS-1:0] c_one_w = WIDTH_BITS'(1);
   localparam logic [COUNT_BITS-1:0] c_one_c = COUNT_BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PULSE   = 3'd1,
      S_GAP     = 3'd2,
      S_DONE    = 3'd3,
      S_HOLDOFF = 3'd4
   } state_t;

   state_t                r_state;
   logic                  r_trig_d;
   logic [WIDTH_BITS-1:0] r_cfg_width;
   logic [WIDTH_BITS-1:0] r_cfg_gap;
   logic [COUNT_BITS-1:0] r_cfg_count;
   logic [WIDTH_BITS-1:0] r_snap_width;
   logic [WIDTH_BITS-1:0] r_snap_gap;
   logic [COUNT_BITS-1:0] r_remaining;
   logic [WIDTH_BITS-1:0] r_cnt;
   logic                  r_glitch;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_clamped;

   logic                  w_edge;
   logic                  w_clamp_hit;
   logic [WIDTH_BITS-1:0] w_eff_width;
   logic [WIDTH_BITS-1:0] w_gap_load;

   assign w_edge = trigger & ~r_trig_d;

`ifdef GLITCH_CLAMP_EN
   localparam logic [WIDTH_BITS-1:0] c_max_width = WIDTH_BITS'(MAX_WIDTH);
   assign w_clamp_hit = (r_cfg_width > c_max_width);
   assign w_eff_width = w_clamp_hit ? c_max_width : r_cfg_width;
`else
   logic w_unused_max;
   assign w_unused_max = (MAX_WIDTH != 0);
   assign w_clamp_hit  = 1'b0;
   assign w_eff_width  = r_cfg_width;
`endif

   // The counters hold "cycles left minus one", so a gap of 0 loads the
   // same value as a gap of 1. This keeps consecutive pulses distinct.
   assign w_gap_load = (r_snap_gap == '0) ? '0 : (r_snap_gap - c_one_w);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_trig_d     <= 1'b0;
         r_cfg_width  <= '0;
         r_cfg_gap    <= '0;
         r_cfg_count  <= '0;
         r_snap_width <= '0;
         r_snap_gap   <= '0;
         r_remaining  <= '0;
         r_cnt        <= '0;
         r_glitch     <= c_off;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_clamped    <= 1'b0;
      end else begin
         r_trig_d <= trigger;
         r_done   <= 1'b0;

         // Config regs may load in any state. The running burst only reads
         // its snapshot, so a new config takes effect on the next burst.
         if (set_config) begin
            r_cfg_width <= width;
            r_cfg_gap   <= gap;
            r_cfg_count <= count;
         end

         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  r_snap_width <= w_eff_width;
                  r_snap_gap   <= r_cfg_gap;
                  r_remaining  <= r_cfg_count;
                  if (r_cfg_count == '0 || w_eff_width == '0) begin
                     // Empty burst: report completion, never assert busy.
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= S_PULSE;
                     r_glitch <= c_on;
                     r_busy   <= 1'b1;
                     r_cnt    <= w_eff_width - c_one_w;
                     if (w_clamp_hit) begin
                        r_clamped <= 1'b1;
                     end
                  end
               end
            end

            S_PULSE: begin
               if (r_cnt == '0) begin
                  r_glitch    <= c_off;
                  r_remaining <= r_remaining - c_one_c;
                  if (r_remaining == c_one_c) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_GAP;
                     r_cnt   <= w_gap_load;
                  end
               end else begin
                  r_cnt <= r_cnt - c_one_w;
               end
            end

            S_GAP: begin
               if (r_cnt == '0) begin
                  r_state  <= S_PULSE;
                  r_glitch <= c_on;
                  r_cnt    <= r_snap_width - c_one_w;
               end else begin
                  r_cnt <= r_cnt - c_one_w;
               end
            end

            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_HOLDOFF;
            end

            // A trigger still held high must not re-fire the generator.
            S_HOLDOFF: begin
               if (!trigger) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state  <= S_IDLE;
               r_glitch <= c_off;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign glitch_out = r_glitch;
   assign busy       = r_busy;
   assign done       = r_done;
   assign clamped    = r_clamped;

endmodule
`default_nettype wire

// File: tb/tb_glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glitch_pulse_gen
//  Purpose  : Self-checking bench for glitch_pulse_gen. It uses a table of
//             burst configurations with hand-computed pulse shapes, followed
//             by hand-written sequences for the held trigger, an edge while
//             busy, a config change, the clamp, and a reset mid-pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_pulse_gen;

   localparam int WB = 16;
   localparam int CB = 8;
`ifdef GLITCH_CLAMP_EN
   localparam int CL      = 8;
   localparam int CLAMP_E = 1;
`else
   localparam int CL      = 20;
   localparam int CLAMP_E = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          trigger;
   logic [WB-1:0] width;
   logic [WB-1:0] gap;
   logic [CB-1:0] count;
   logic          set_config;
   logic          glitch_out;
   logic          busy;
   logic          done;
   logic          clamped;

   glitch_pulse_gen #(
      .WIDTH_BITS (WB),
      .COUNT_BITS (CB),
      .MAX_WIDTH  (8),
      .OUT_ACTIVE (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .trigger    (trigger),
      .width      (width),
      .gap        (gap),
      .count      (count),
      .set_config (set_config),
      .glitch_out (glitch_out),
      .busy       (busy),
      .done       (done),
      .clamped    (clamped)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic tr_g [0:255];
   logic tr_b [0:255];
   logic tr_d [0:255];

   int a_pulses, a_len, a_gap, a_first, a_active, a_busy, a_done, a_done_at;

   typedef struct {
      int w, g, c;
      int pulses, len, gp, active, bsy, done_at;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int w, input int g, input int c);
      width      = WB'(w);
      gap        = WB'(g);
      count      = CB'(c);
      set_config = 1'b1;
      step();
      set_config = 1'b0;
   endtask

   // Trigger is high in cycle 0 (the edge cycle t). Sample k is cycle t+k.
   // The trigger stays high through cycle hold-1 and is raised again for
   // the single cycle re_at (when re_at is nonzero).
   task automatic capture(input int ncyc, input int hold, input int re_at);
      trigger = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         tr_g[k]    = (glitch_out === 1'b1);
         tr_b[k]    = (busy === 1'b1);
         tr_d[k]    = (done === 1'b1);
         set_config = 1'b0;
         trigger    = (k < hold) || (k == re_at);
      end
      trigger = 1'b0;
   endtask

   task automatic analyze(input int n);
      int k;
      int j;
      int g;
      a_pulses = 0; a_len = 0; a_gap = 0; a_first = 0;
      a_active = 0; a_busy = 0; a_done = 0; a_done_at = 0;
      for (int i = 1; i <= n; i++) begin
         if (tr_g[i]) a_active++;
         if (tr_g[i] && (i == 1 || !tr_g[i-1])) a_pulses++;
         if (tr_b[i]) a_busy++;
         if (tr_d[i]) begin
            a_done++;
            if (a_done_at == 0) a_done_at = i;
         end
      end
      k = 1;
      while (k <= n && !tr_g[k]) k++;
      a_first = (k <= n) ? k : 0;
      while (k <= n && tr_g[k]) begin
         a_len++;
         k++;
      end
      j = k;
      g = 0;
      while (j <= n && !tr_g[j]) begin
         g++;
         j++;
      end
      a_gap = (j <= n && a_len > 0) ? g : 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //               w   g  c  pulses len gap active busy done_at
      vecs[0] = '{ 3,  2, 2, 2,  3,  2,  6,  9,  9};
      vecs[1] = '{ 5,  0, 0, 0,  0,  0,  0,  0,  1};
      vecs[2] = '{ 4,  0, 3, 3,  4,  1, 12, 15, 15};
      vecs[3] = '{ 0,  3, 4, 0,  0,  0,  0,  0,  1};
      vecs[4] = '{ 1,  1, 1, 1,  1,  0,  1,  2,  2};
      vecs[5] = '{ 2,  5, 3, 3,  2,  5,  6, 17, 17};
      vecs[6] = '{ 1,  0, 4, 4,  1,  1,  4,  8,  8};
      vecs[7] = '{20,  1, 1, 1, CL,  0, CL, CL+1, CL+1};

      rst = 1'b0; trigger = 1'b0; set_config = 1'b0;
      width = '0; gap = '0; count = '0;
      repeat (3) step();
      chk("reset_glitch_out", 32'(glitch_out), 0);
      chk("reset_busy",       32'(busy),       0);
      chk("reset_done",       32'(done),       0);
      chk("reset_clamped",    32'(clamped),    0);
      rst = 1'b1;
      step();

      for (int v = 0; v < 8; v++) begin
         set_cfg(vecs[v].w, vecs[v].g, vecs[v].c);
         capture(40, 1, 0);
         analyze(40);
         chk($sformatf("v%0d_pulses", v),  a_pulses,  vecs[v].pulses);
         chk($sformatf("v%0d_len", v),     a_len,     vecs[v].len);
         chk($sformatf("v%0d_gap", v),     a_gap,     vecs[v].gp);
         chk($sformatf("v%0d_first", v),   a_first,   (vecs[v].pulses > 0) ? 1 : 0);
         chk($sformatf("v%0d_active", v),  a_active,  vecs[v].active);
         chk($sformatf("v%0d_busy", v),    a_busy,    vecs[v].bsy);
         chk($sformatf("v%0d_done_cnt", v), a_done,   1);
         chk($sformatf("v%0d_done_at", v), a_done_at, vecs[v].done_at);
      end
      chk("clamped_after_w20", 32'(clamped), CLAMP_E);

      // The clamped flag must stay set through a burst that does not clamp.
      set_cfg(5, 1, 1);
      capture(20, 1, 0);
      analyze(20);
      chk("noclamp_len", a_len, 5);
      chk("clamped_sticky", 32'(clamped), CLAMP_E);

      // Trigger held high for 50 cycles: exactly one burst.
      set_cfg(2, 1, 1);
      capture(60, 50, 0);
      analyze(60);
      chk("held_pulses", a_pulses, 1);
      chk("held_active", a_active, 2);
      chk("held_done",   a_done,   1);

      // A second edge during a busy burst is ignored. A later edge fires again.
      set_cfg(2, 1, 3);
      capture(30, 1, 3);
      analyze(30);
      chk("reedge_pulses", a_pulses, 3);
      chk("reedge_done",   a_done,   1);
      chk("reedge_busy",   a_busy,   9);
      capture(30, 1, 0);
      analyze(30);
      chk("after_pulses", a_pulses, 3);

      // Change the config mid-burst: the running burst keeps width 2.
      set_cfg(2, 1, 2);
      trigger = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         tr_g[k] = (glitch_out === 1'b1);
         tr_b[k] = (busy === 1'b1);
         tr_d[k] = (done === 1'b1);
         trigger = 1'b0;
         if (k == 2) begin
            width = 16'd10; set_config = 1'b1;
         end else begin
            set_config = 1'b0;
         end
      end
      analyze(20);
      chk("midcfg_len",    a_len,    2);
      chk("midcfg_active", a_active, 4);
      capture(40, 1, 0);
      analyze(40);
      chk("nextcfg_len",    a_len,    10);
      chk("nextcfg_pulses", a_pulses, 2);

      // set_config in the same cycle as the edge: the burst uses the old width.
      width = 16'd3; gap = 16'd1; count = 8'd2; set_config = 1'b1;
      capture(40, 1, 0);
      analyze(40);
      chk("samecyc_len_old", a_len, 10);
      capture(40, 1, 0);
      analyze(40);
      chk("samecyc_len_new", a_len, 3);

      // A reset mid-pulse drops the output at once, before the next clock edge.
      set_cfg(10, 1, 1);
      trigger = 1'b1;
      step(); trigger = 1'b0;
      step(); step();
      chk("pre_reset_active", 32'(glitch_out), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_glitch", 32'(glitch_out), 0);
      chk("async_rst_busy",   32'(busy),       0);
      chk("async_rst_clamp",  32'(clamped),    0);
      step();
      rst = 1'b1;
      step();
      // The config regs were cleared, so count is 0: no pulse, a single done.
      capture(10, 1, 0);
      analyze(10);
      chk("postrst_pulses", a_pulses, 0);
      chk("postrst_done",   a_done,   1);
      chk("postrst_busy",   a_busy,   0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
